sha256_sequencer: RTL and testbench
===================================

# sha256_sequencer

Control FSM that drives the SHA-256 `core` datapath across a multi-block message. It pulses hash initialisation, requests each 512-bit block from the message buffer, enables the 64 compression rounds, and triggers the per-block digest accumulation. It signals completion once the last block has been accumulated into `hash_val`. It sits between the top-level command interface and `core`, and owns every `core` control input.

## Interface
- `BLK_W`, default 8: width of the block count and block index.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin hashing; sampled only in IDLE.
- `num_blocks`  in  BLK_W  number of 512-bit blocks; latched when `start` is accepted.
- `block_ack`  in  1  message buffer has block `block_idx` ready for the core to read.
- `finish_loop`  in  1  round-63 flag returned by `core`.
- `block_req`  out  1  request for block `block_idx`; held high until acked.
- `block_idx`  out  BLK_W  index of the current block.
- `core_en`  out  1  round enable to `core`.
- `core_clr`  out  1  clears the round counter in `core`.
- `load_hash_val`  out  1  digest load/accumulate strobe to `core`.
- `initial_hash_val`  out  1  selects H0 on a load.
- `busy`  out  1  high from the start of INIT to the end of DONE.
- `done`  out  1  one-cycle completion pulse.
- `sync_err`  out  1  sticky: round count and `finish_loop` disagreed.

## Operation
- All outputs are registered Moore outputs, decoded from state.
- **States:** IDLE, INIT, FETCH, ROUND, ACCUM, DONE.
- **IDLE:** all outputs 0. `start`=1 latches `num_blocks`, clears `block_idx` and `sync_err`, then moves to INIT. If `num_blocks`=0, go directly to DONE with no core activity.
- **INIT** (1 cycle): `load_hash_val`=1, `initial_hash_val`=1, `core_clr`=1. Next state is FETCH.
- **FETCH:** `block_req`=1 and `core_clr`=1 on every cycle. When `block_ack`=1 is sampled, move to ROUND with the 6-bit round counter at 0. `block_ack` while not in FETCH is ignored.
- **ROUND:** `core_en`=1 and the round counter increments each cycle. At count 63, move to ACCUM.
  - If `finish_loop`≠1 at count 63, or `finish_loop`=1 at any count below 63, set `sync_err`. Sequencing continues regardless.
- **ACCUM** (1 cycle): `load_hash_val`=1, `initial_hash_val`=0.
  - If `block_idx`=latched count−1, go to DONE.
  - Otherwise increment `block_idx` and go to FETCH.
- **DONE** (1 cycle): `done`=1. Next state is IDLE. `block_idx` holds its final value until the next start.
- **Arithmetic:** `block_idx` never wraps, since the maximum is 2^BLK_W−1 blocks, so the last index is 2^BLK_W−2. The round counter wraps 63→0 only on entry to ROUND.
- `start` during `busy` is ignored; the latched count is unaffected.
- Reset mid-operation returns the FSM to IDLE on assertion, with all outputs 0 and `sync_err` cleared. No `done` is produced for the aborted message.

## Timing
- **Reset value:** every output 0, state IDLE, `block_idx`=0.
- With `start` sampled at edge T and zero-wait acks:
  - INIT at cycle T+1.
  - FETCH at T+2.
  - ROUND at T+3..T+66.
  - ACCUM at T+67.
  - `done` at T+2+66·N.
- Each cycle of `block_ack` latency adds one FETCH cycle per block.
- `core_en` is high for exactly 64 cycles per block.
- `load_hash_val` is high for exactly N+1 single-cycle pulses per message.
- `num_blocks`=0: `done` at T+1, `busy` high for that cycle only.
- `block_req` falls in the cycle after `block_ack` is sampled.

## Test plan
- **Single block, immediate ack:** `num_blocks`=1, `block_ack` tied high, `start` at T.
  - INIT at T+1, 64 `core_en` cycles T+3..T+66, ACCUM at T+67, `done` at T+68.
  - `sync_err`=0.
  - With the "abc" padded block loaded, `hash_val`=ba7816bf…f20015ad.
- **Three blocks, ack delayed 5 cycles per request:**
  - `block_idx` steps 0,1,2.
  - `done` at T+2+198+15.
  - Exactly 4 `load_hash_val` pulses, only the first with `initial_hash_val`=1.
- **Zero blocks:** `num_blocks`=0.
  - `done` at T+1.
  - `core_en`, `block_req` and `load_hash_val` never asserted.
- **Start while busy:** pulse `start` with `num_blocks`=5 during ROUND of a 2-block job.
  - The job completes as 2 blocks and `done` fires once.
  - IDLE is re-entered afterwards.
- **Async reset mid-ROUND:** drop `rst` at round 30 of block 1.
  - All outputs are 0 immediately.
  - After release, a fresh 1-block job produces the correct digest and `done` at T+68.
- **Sync error:** force `finish_loop`=0 at round 63.
  - `sync_err` rises in the ACCUM cycle and stays high through DONE and IDLE until the next accepted `start`.

Source files
------------

// File: rtl/sha256_sequencer.sv
// Control FSM for the SHA-256 core: initialises the hash, fetches each 512-bit
// block, runs 64 rounds per block, accumulates the digest and reports completion.
module sha256_sequencer #(
    parameter int unsigned BLK_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             block_ack,
    input  logic             finish_loop,
    output logic             block_req,
    output logic [BLK_W-1:0] block_idx,
    output logic             core_en,
    output logic             core_clr,
    output logic             load_hash_val,
    output logic             initial_hash_val,
    output logic             busy,
    output logic             done,
    output logic             sync_err
);

    localparam int unsigned RND_W    = 6;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(63);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_ROUND,
        S_ACCUM,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   nblk_q, nblk_d;
    logic [BLK_W-1:0]   idx_q, idx_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               err_q, err_d;

    logic req_q, req_d;
    logic en_q, en_d;
    logic clr_q, clr_d;
    logic load_q, load_d;
    logic init_q, init_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // State register plus Moore outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            nblk_q  <= '0;
            idx_q   <= '0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nblk_q  <= nblk_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
            req_q   <= req_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counters and output decode
    always_comb begin
        state_d = state_q;
        nblk_d  = nblk_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nblk_d  = num_blocks;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (num_blocks == '0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                if (block_ack) begin
                    rnd_d   = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                // finish_loop must be high exactly on the last round
                if (finish_loop != (rnd_q == RND_LAST)) begin
                    err_d = 1'b1;
                end
                if (rnd_q == RND_LAST) begin
                    state_d = S_ACCUM;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            S_ACCUM: begin
                if (idx_q == nblk_q - BLK_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + BLK_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_FETCH);
        clr_d  = (state_d == S_INIT) || (state_d == S_FETCH);
        en_d   = (state_d == S_ROUND);
        load_d = (state_d == S_INIT) || (state_d == S_ACCUM);
        init_d = (state_d == S_INIT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign block_req        = req_q;
    assign block_idx        = idx_q;
    assign core_en          = en_q;
    assign core_clr         = clr_q;
    assign load_hash_val    = load_q;
    assign initial_hash_val = init_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign sync_err         = err_q;

endmodule

// File: tb/tb_sha256_sequencer.sv
// Scoreboard bench for sha256_sequencer: a job-level timing/count model predicts
// each message's outcome; a monitor checks the DUT's activity against it on done.
module tb_sha256_sequencer;

    localparam int unsigned BLK_W = 8;
    localparam int MAXB = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [BLK_W-1:0] num_blocks = '0;
    logic             block_ack = 1'b0;
    logic             finish_loop = 1'b0;
    logic             block_req;
    logic [BLK_W-1:0] block_idx;
    logic             core_en, core_clr, load_hash_val, initial_hash_val;
    logic             busy, done, sync_err;

    sha256_sequencer #(.BLK_W(BLK_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
        .block_ack(block_ack), .finish_loop(finish_loop),
        .block_req(block_req), .block_idx(block_idx), .core_en(core_en),
        .core_clr(core_clr), .load_hash_val(load_hash_val),
        .initial_hash_val(initial_hash_val), .busy(busy), .done(done),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          t_start;
        int          n;
        int          done_cyc;
        int          n_en;
        int          n_load;
        int          n_init;
        int          n_req;
        int          n_clr;
        int          n_busy;
        int          final_idx;
        int          final_err;
        logic [31:0] err_mask;
    } exp_t;

    exp_t sb[$];

    // Per-job stimulus plan: ack latency and finish_loop fault per block
    int lat_cur[MAXB];
    int err_mode[MAXB];
    int err_round[MAXB];

    // Message-buffer responder, with random ack noise outside FETCH
    int wc = 0, fcnt = 0;
    bit acked = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                wc = 0; fcnt = 0; acked = 0; block_ack = 1'b0;
            end else begin
                if (load_hash_val && initial_hash_val) begin
                    fcnt = 0; wc = 0; acked = 0;
                end
                if (block_req) begin
                    if (wc >= lat_cur[fcnt % MAXB]) begin
                        block_ack = 1'b1; acked = 1;
                    end else begin
                        block_ack = 1'b0; wc++;
                    end
                end else begin
                    if (acked) begin
                        fcnt++; wc = 0; acked = 0;
                    end
                    block_ack = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Core stand-in: raises finish_loop on round 63 unless a fault is planned
    int rc = 0, cblk = 0;
    initial begin
        int r;
        logic fl;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                rc = 0; cblk = 0; finish_loop = 1'b0;
            end else begin
                if (load_hash_val && initial_hash_val) begin
                    rc = 0; cblk = 0;
                end
                if (core_en) rc++;
                else if (rc > 0) begin
                    cblk++; rc = 0;
                end
                finish_loop = 1'b0;
                if (core_en && cblk < MAXB) begin
                    r  = rc - 1;
                    fl = (r == 63);
                    if (err_mode[cblk] == 1 && r == 63) fl = 1'b0;
                    if (err_mode[cblk] == 2 && r == err_round[cblk]) fl = 1'b1;
                    finish_loop = fl;
                end
            end
        end
    end

    // Monitor: accumulates per-job activity and compares on each done
    int m_en = 0, m_load = 0, m_init = 0, m_req = 0, m_clr = 0, m_busy = 0;
    int m_acc = 0, m_idle_bad = 0, jobs_done = 0;
    bit post_done = 0;
    int post_err = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                m_en = 0; m_load = 0; m_init = 0; m_req = 0; m_clr = 0;
                m_busy = 0; m_acc = 0; m_idle_bad = 0; post_done = 0;
                continue;
            end
            if (post_done) begin
                post_done = 0;
                check("idle_after_done_busy", busy, 0);
                check("idle_after_done_sync_err", sync_err, post_err);
            end
            if (core_en) m_en++;
            if (load_hash_val) m_load++;
            if (block_req) m_req++;
            if (core_clr) m_clr++;
            if (busy) m_busy++;
            if (!busy && (core_en || block_req || load_hash_val || core_clr ||
                          initial_hash_val || done))
                m_idle_bad++;
            if (load_hash_val && initial_hash_val) begin
                m_init++;
                check("sync_err_cleared_at_init", sync_err, 0);
            end
            if (load_hash_val && !initial_hash_val && sb.size() > 0) begin
                check("accum_block_idx", block_idx, m_acc);
                check("accum_sync_err", sync_err, sb[0].err_mask[m_acc % 32]);
                m_acc++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc + 1, e.done_cyc);
                    check("core_en_cycles", m_en, e.n_en);
                    check("load_pulses", m_load, e.n_load);
                    check("initial_loads", m_init, e.n_init);
                    check("block_req_cycles", m_req, e.n_req);
                    check("core_clr_cycles", m_clr, e.n_clr);
                    check("busy_cycles", m_busy, e.n_busy);
                    check("final_block_idx", block_idx, e.final_idx);
                    check("done_sync_err", sync_err, e.final_err);
                    check("idle_outputs_quiet", m_idle_bad, 0);
                    post_err  = e.final_err;
                    post_done = 1;
                end
                m_en = 0; m_load = 0; m_init = 0; m_req = 0; m_clr = 0;
                m_busy = 0; m_acc = 0; m_idle_bad = 0;
                jobs_done++;
            end
        end
    end

    // Fill the stimulus plan and derive the job's expected outcome
    task automatic plan_job(input int n, input int lat_fix, input int err_pct,
                            input int force_err_blk, output exp_t e);
        int sum_fetch;
        bit any;
        sum_fetch = 0;
        any = 0;
        e.err_mask = '0;
        for (int b = 0; b < MAXB; b++) begin
            lat_cur[b]   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
            err_mode[b]  = 0;
            err_round[b] = int'($urandom_range(0, 62));
            if (int'($urandom_range(0, 99)) < err_pct)
                err_mode[b] = int'($urandom_range(1, 2));
            if (b == force_err_blk) err_mode[b] = 1;
        end
        for (int b = 0; b < n; b++) begin
            sum_fetch += lat_cur[b] + 1;
            if (err_mode[b] != 0) any = 1;
            e.err_mask[b] = any;
        end
        e.n         = n;
        e.n_en      = 64 * n;
        e.n_load    = (n > 0) ? n + 1 : 0;
        e.n_init    = (n > 0) ? 1 : 0;
        e.n_req     = sum_fetch;
        e.n_clr     = (n > 0) ? sum_fetch + 1 : 0;
        e.final_idx = (n > 0) ? n - 1 : 0;
        e.final_err = any ? 1 : 0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            if (!busy && !post_done && sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (k == 3000) check("idle_timeout", 0, 1);
    endtask

    task automatic run_job(input int n, input int lat_fix, input int err_pct,
                           input int force_err_blk, input bit busy_start);
        exp_t e;
        int target, k, dur;
        wait_idle();
        plan_job(n, lat_fix, err_pct, force_err_blk, e);
        // Start is sampled at the next edge, which is cycle T
        e.t_start = cyc + 1;
        dur = (n > 0) ? 2 + 64 * n + n + e.n_req : 1;
        e.done_cyc = e.t_start + dur;
        e.n_busy   = dur;
        sb.push_back(e);
        target = jobs_done + 1;
        start = 1'b1;
        num_blocks = BLK_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num_blocks = BLK_W'($urandom_range(0, 255));
        if (busy_start && n > 0) begin
            repeat ($urandom_range(5, 60)) @(posedge clk);
            #1;
            if (busy) begin
                start = 1'b1;
                num_blocks = BLK_W'(5);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        for (k = 0; k < dur + 100; k++) begin
            if (jobs_done >= target) break;
            @(posedge clk); #1;
        end
        if (jobs_done < target) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic reset_mid_round();
        exp_t e;
        int k;
        wait_idle();
        plan_job(2, 0, 0, -1, e);
        e.t_start = cyc + 1;
        e.done_cyc = 0;
        sb.push_back(e);
        start = 1'b1;
        num_blocks = BLK_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 500; k++) begin
            @(posedge clk); #2;
            if (cblk == 1 && rc == 31) break;
        end
        check("reached_round30_blk1", (cblk == 1 && rc == 31) ? 1 : 0, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_core_en", core_en, 0);
        check("rst_block_req", block_req, 0);
        check("rst_load", load_hash_val, 0);
        check("rst_initial", initial_hash_val, 0);
        check("rst_core_clr", core_clr, 0);
        check("rst_done", done, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_block_idx", block_idx, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < MAXB; b++) begin
            lat_cur[b] = 0; err_mode[b] = 0; err_round[b] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_core_en", core_en, 0);
        check("reset_block_req", block_req, 0);
        check("reset_load", load_hash_val, 0);
        check("reset_sync_err", sync_err, 0);
        check("reset_block_idx", block_idx, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_job(1, 0, 0, -1, 0);    // single block, immediate ack
        run_job(3, 5, 0, -1, 0);    // three blocks, 5-cycle ack latency
        run_job(0, 0, 0, -1, 0);    // zero blocks
        run_job(2, 0, 0, -1, 1);    // start while busy
        reset_mid_round();
        run_job(1, 0, 0, -1, 0);    // fresh job after abort
        run_job(1, 0, 0, 0, 0);     // finish_loop missing at round 63
        run_job(2, 1, 0, -1, 0);    // sync_err cleared by next start
        for (int j = 0; j < 14; j++)
            run_job(int'($urandom_range(0, 6)), -1, 20, -1, bit'($urandom_range(0, 1)));
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
